// File: rtl/m_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : m_fetch_unit_if
//  Description : Signal bundle between the fetch unit and its surroundings.
//                It groups the instruction memory bus, the decoder
//                valid/ready handshake and the stall/redirect controls.
//                The master modport is the fetch unit's view. The slave
//                modport is the view of the memory, the decoder and the
//                control logic.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals (direction seen from the master):
//    w_bus_addr     out 8    instruction memory address (fetch PC)
//    w_bus_data     in  8    instruction byte, same-cycle return
//    w_instr        out 8    byte at the queue head (0 when empty)
//    w_instr_pc     out 8    address of the head byte (0 when empty)
//    w_instr_valid  out 1    queue non-empty
//    w_instr_ready  in  1    decoder accepts the head this cycle
//    w_stall        in  1    suppress new fetches
//    w_redirect     in  1    flush queue, restart fetch at w_redirect_pc
//    w_redirect_pc  in  8    redirect target
//    w_queue_count  out CW   occupied entries, CW = log2(QUEUE_DEPTH)+1
// ============================================================================
interface m_fetch_unit_if #(
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned c_cnt_w = $clog2(QUEUE_DEPTH) + 1;

    logic [7:0]         w_bus_addr;
    logic [7:0]         w_bus_data;
    logic [7:0]         w_instr;
    logic [7:0]         w_instr_pc;
    logic               w_instr_valid;
    logic               w_instr_ready;
    logic               w_stall;
    logic               w_redirect;
    logic [7:0]         w_redirect_pc;
    logic [c_cnt_w-1:0] w_queue_count;

    modport master (
        output w_bus_addr,
        input  w_bus_data,
        output w_instr,
        output w_instr_pc,
        output w_instr_valid,
        input  w_instr_ready,
        input  w_stall,
        input  w_redirect,
        input  w_redirect_pc,
        output w_queue_count
    );

    modport slave (
        input  w_bus_addr,
        output w_bus_data,
        input  w_instr,
        input  w_instr_pc,
        input  w_instr_valid,
        output w_instr_ready,
        output w_stall,
        output w_redirect,
        output w_redirect_pc,
        input  w_queue_count
    );
endinterface
`default_nettype wire

// File: rtl/m_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : m_fetch_unit
//  Description : Instruction fetch stage and instruction memory bus master.
//                The unit holds the fetch PC and drives it as the bus
//                address. Each returned byte is buffered with its address
//                in a circular prefetch queue. The queue head is offered to
//                the decoder over a valid/ready handshake. A stall holds the
//                PC while the queue keeps draining. A redirect flushes the
//                queue and reloads the PC.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters:
//    QUEUE_DEPTH  prefetch queue entries (power of two, >= 2)
//    RESET_PC     fetch address after reset
//  Ports:
//    w_clock      in   system clock, rising edge
//    w_reset      in   asynchronous active-low reset
//    bus          m_fetch_unit_if.master (memory bus, decoder handshake,
//                 stall/redirect controls, occupancy)
// ============================================================================
module m_fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [7:0]  RESET_PC    = 8'h00
) (
    input  wire logic        w_clock,
    input  wire logic        w_reset,
    m_fetch_unit_if.master   bus
);

    localparam int unsigned c_ptr_w = $clog2(QUEUE_DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(QUEUE_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]          pc_q,     pc_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]  count_q,  count_d;

    // Each entry holds {address, byte}. The storage is not reset because
    // nothing reads it while the count is zero.
    logic [15:0]         mem_q [QUEUE_DEPTH];

    logic                w_valid;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic [15:0]         w_head;

    // ------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------
    assign w_valid = (count_q != '0);
    assign w_full  = (count_q == c_depth);

    // A redirect cancels both the pop and the push of its cycle.
    assign w_pop   = w_valid && bus.w_instr_ready && !bus.w_redirect;

    // A full queue may still push when the head leaves in the same cycle.
    // w_instr_ready reaches only the push enable. It never reaches the
    // bus address, which is taken directly from pc_q.
    assign w_push  = !bus.w_stall && !bus.w_redirect && (!w_full || w_pop);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (bus.w_redirect) begin
            pc_d     = bus.w_redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                // The PC wraps from 8'hFF to 8'h00 through the natural
                // 8-bit overflow.
                pc_d     = pc_q + 8'd1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge w_clock or negedge w_reset) begin
        if (!w_reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    always_ff @(posedge w_clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {pc_q, bus.w_bus_data};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_head            = mem_q[rd_ptr_q];

    assign bus.w_bus_addr    = pc_q;
    assign bus.w_instr_valid = w_valid;
    assign bus.w_instr       = w_valid ? w_head[7:0]  : 8'h00;
    assign bus.w_instr_pc    = w_valid ? w_head[15:8] : 8'h00;
    assign bus.w_queue_count = count_q;

endmodule
`default_nettype wire
